// File: rtl/output_checker_pkg.sv
// Shared state encoding, default MISR constants and the vector fold helper
// used by the output signature checker and its MISR sub-blocks.
package output_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

  // fold() accepts vectors up to FOLD_MAX_W bits and signatures up to FOLD_MAX_SIG bits.
  localparam int FOLD_MAX_W   = 256;
  localparam int FOLD_IW      = 8;
  localparam int FOLD_MAX_SIG = 64;
  localparam int FOLD_SIG_IW  = 6;

  // Bit i of the zero-extended vector lands in lane i % sig_w, i.e. an XOR of sig_w-wide chunks.
  function automatic logic [FOLD_MAX_SIG-1:0] fold(input logic [FOLD_MAX_W-1:0] v,
                                                   input int sig_w);
    logic [FOLD_MAX_SIG-1:0] r;
    r = '0;
    for (int i = 0; i < FOLD_MAX_W; i++) begin
      r[FOLD_SIG_IW'(i % sig_w)] = r[FOLD_SIG_IW'(i % sig_w)] ^ v[FOLD_IW'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/output_signature_checker_misr.sv
// Multiple-input signature register: folds each enabled input vector into a
// SIG_W-bit Galois LFSR signature; clear reloads the seed.
module misr_compactor
  import output_checker_pkg::*;
#(
  parameter int               WIDTH = 127,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_fold;
  logic [SIG_W-1:0] w_feedback;
  logic [SIG_W-1:0] w_next;

  assign w_fold     = SIG_W'(fold(FOLD_MAX_W'(i_data), SIG_W));
  assign w_feedback = r_sig[SIG_W-1] ? POLY : '0;
  assign w_next     = {r_sig[SIG_W-2:0], 1'b0} ^ w_feedback ^ w_fold;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig <= SEED;
    end else if (i_clear) begin
      r_sig <= SEED;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/output_signature_checker.sv
// Compacts reference and netlist result streams into MISR signatures, compares
// them sample by sample and reports the first divergence plus a pass verdict.
module output_signature_checker
  import output_checker_pkg::*;
#(
  parameter int               WIDTH       = 127,
  parameter int               SIG_W       = 32,
  parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED        = SIG_W'(DEF_SEED),
  parameter int               CNT_W       = 16,
  parameter int               NUM_SAMPLES = 21
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sample_valid,
  input  logic [WIDTH-1:0] i_y_ref,
  input  logic [WIDTH-1:0] i_y_dut,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_mm_count,
  output logic [CNT_W-1:0] o_first_mm_idx,
  output logic [WIDTH-1:0] o_first_mm_xor,
  output logic [SIG_W-1:0] o_sig_ref,
  output logic [SIG_W-1:0] o_sig_dut,
  output logic             o_pass
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_mm_count;
  logic [CNT_W-1:0] r_first_idx;
  logic [WIDTH-1:0] r_first_xor;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_diff;

  // start wins over a coincident sample, which is dropped rather than folded in.
  assign w_accept = (r_state == ST_RUN) && i_sample_valid && !i_start;
  assign w_last   = (r_sample_cnt == LAST_IDX);
  assign w_diff   = i_y_ref ^ i_y_dut;

  misr_compactor #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr_ref (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_start),
    .i_en    (w_accept),
    .i_data  (i_y_ref),
    .o_sig   (o_sig_ref)
  );

  misr_compactor #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_start),
    .i_en    (w_accept),
    .i_data  (i_y_dut),
    .o_sig   (o_sig_dut)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mismatch   <= 1'b0;
      r_sample_cnt <= '0;
      r_mm_count   <= '0;
      r_first_idx  <= '0;
      r_first_xor  <= '0;
    end else if (i_start) begin
      r_state      <= ST_RUN;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_mismatch   <= 1'b0;
      r_sample_cnt <= '0;
      r_mm_count   <= '0;
      r_first_idx  <= '0;
      r_first_xor  <= '0;
    end else if (w_accept) begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
      if (w_diff != '0) begin
        if (r_mm_count != '1) begin
          r_mm_count <= r_mm_count + 1'b1;
        end
        if (!r_mismatch) begin
          r_mismatch  <= 1'b1;
          r_first_idx <= r_sample_cnt;
          r_first_xor <= w_diff;
        end
      end
      if (w_last) begin
        r_state <= ST_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_mismatch     = r_mismatch;
  assign o_mm_count     = r_mm_count;
  assign o_first_mm_idx = r_first_idx;
  assign o_first_mm_xor = r_first_xor;
  assign o_pass         = r_done && !r_mismatch && (o_sig_ref == o_sig_dut);

endmodule
